// File: rtl/sync_event_sched_if.sv
// rtl/sync_event_sched_if.sv - requester strobes, analog sync channel and status of the event scheduler
interface sync_event_sched_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic [N-1:0]   ev_strobe;
  logic [N-1:0]   ev_level;
  logic           sync_valid;
  logic [IDW-1:0] sync_id;
  logic           sync_level;
  logic           sync_ack;
  logic [N-1:0]   pending;
  logic           busy;
  logic [7:0]     coalesce_cnt;
  logic           err_timeout;

  modport master (
    input  ev_strobe, ev_level, sync_ack,
    output sync_valid, sync_id, sync_level, pending, busy, coalesce_cnt, err_timeout
  );

  modport slave (
    output ev_strobe, ev_level, sync_ack,
    input  sync_valid, sync_id, sync_level, pending, busy, coalesce_cnt, err_timeout
  );
endinterface

// File: rtl/sync_event_sched.sv
// rtl/sync_event_sched.sv - round-robin serialiser of cell level changes onto the analog sync channel
module sync_event_sched #(
  parameter int N       = 4,
  parameter int IDW     = 2,
  parameter int HOLDOFF = 2,
  parameter int TIMEOUT = 64
) (
  input logic                clk,
  input logic                rst,
  sync_event_sched_if.master bus
);

  localparam int ACW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int HCW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [ACW-1:0] ACK_LAST  = ACW'(TIMEOUT - 1);
  localparam logic [HCW-1:0] HOLD_LOAD = HCW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   pend, plev, last;
  logic [N-1:0]   pend_nxt, plev_nxt, last_nxt;
  logic [IDW-1:0] last_grant, last_grant_nxt;
  logic [ACW-1:0] ack_cnt, ack_cnt_nxt;
  logic [HCW-1:0] hold_cnt, hold_cnt_nxt;
  logic           valid_q, valid_nxt;
  logic [IDW-1:0] id_q, id_nxt;
  logic           level_q, level_nxt;
  logic           err_q, err_nxt;
  logic [7:0]     ccnt_q, ccnt_nxt;
  logic           busy_q, busy_nxt;

  logic           grant_hit;
  logic [IDW-1:0] grant_idx;
  logic [IDW:0]   cand;
  logic           issue_done;
  logic [4:0]     coal_hits;
  logic [8:0]     csum;

  assign issue_done = bus.sync_ack || (ack_cnt == ACK_LAST);

  // Rotating priority: first pending index after the last one granted, with wrap.
  always_comb begin
    grant_hit = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, last_grant} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(N)) cand = cand - (IDW+1)'(N);
      if (!grant_hit && pend[cand[IDW-1:0]]) begin
        grant_hit = 1'b1;
        grant_idx = cand[IDW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_hit)  state_nxt = ISSUE;
      ISSUE:   if (issue_done) state_nxt = (HOLDOFF == 0) ? IDLE : HOLD;
      HOLD:    if (hold_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pend_nxt       = pend;
    plev_nxt       = plev;
    last_nxt       = last;
    last_grant_nxt = last_grant;
    ack_cnt_nxt    = ack_cnt;
    hold_cnt_nxt   = hold_cnt;
    valid_nxt      = valid_q;
    id_nxt         = id_q;
    level_nxt      = level_q;
    err_nxt        = err_q;
    coal_hits      = '0;
    csum           = '0;
    ccnt_nxt       = ccnt_q;
    busy_nxt       = 1'b0;

    case (state)
      IDLE: begin
        if (grant_hit) begin
          last_grant_nxt      = grant_idx;
          id_nxt              = grant_idx;
          level_nxt           = plev[grant_idx];
          last_nxt[grant_idx] = plev[grant_idx];
          pend_nxt[grant_idx] = 1'b0;
          valid_nxt           = 1'b1;
          ack_cnt_nxt         = '0;
        end
      end
      ISSUE: begin
        if (issue_done) begin
          valid_nxt    = 1'b0;
          hold_cnt_nxt = HOLD_LOAD;
          if (!bus.sync_ack) err_nxt = 1'b1;
        end else begin
          ack_cnt_nxt = ack_cnt + 1'b1;
        end
      end
      HOLD: begin
        if (hold_cnt != '0) hold_cnt_nxt = hold_cnt - 1'b1;
      end
      default: ;
    endcase

    // Filter runs after the grant so a same-cycle strobe for the granted cell
    // sees its freshly issued level and can re-arm pend over the grant clear.
    for (int i = 0; i < N; i++) begin
      if (bus.ev_strobe[i]) begin
        if (pend_nxt[i]) begin
          plev_nxt[i] = bus.ev_level[i];
          coal_hits   = coal_hits + 5'd1;
        end else if (bus.ev_level[i] != last_nxt[i]) begin
          pend_nxt[i] = 1'b1;
          plev_nxt[i] = bus.ev_level[i];
        end
      end
    end

    csum     = {1'b0, ccnt_q} + {4'b0, coal_hits};
    ccnt_nxt = csum[8] ? 8'hff : csum[7:0];
    busy_nxt = (state_nxt != IDLE) || (|pend_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend       <= '0;
      plev       <= '0;
      last       <= '0;
      last_grant <= IDW'(N - 1);
      ack_cnt    <= '0;
      hold_cnt   <= '0;
      valid_q    <= 1'b0;
      id_q       <= '0;
      level_q    <= 1'b0;
      err_q      <= 1'b0;
      ccnt_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      pend       <= pend_nxt;
      plev       <= plev_nxt;
      last       <= last_nxt;
      last_grant <= last_grant_nxt;
      ack_cnt    <= ack_cnt_nxt;
      hold_cnt   <= hold_cnt_nxt;
      valid_q    <= valid_nxt;
      id_q       <= id_nxt;
      level_q    <= level_nxt;
      err_q      <= err_nxt;
      ccnt_q     <= ccnt_nxt;
      busy_q     <= busy_nxt;
    end
  end

  assign bus.sync_valid   = valid_q;
  assign bus.sync_id      = id_q;
  assign bus.sync_level   = level_q;
  assign bus.pending      = pend;
  assign bus.busy         = busy_q;
  assign bus.coalesce_cnt = ccnt_q;
  assign bus.err_timeout  = err_q;

endmodule

// File: tb/tb_sync_event_sched.sv
// tb/tb_sync_event_sched.sv - directed and randomized check of sync_event_sched against an event-level model
module tb_sync_event_sched;

  localparam int N       = 4;
  localparam int IDW     = 2;
  localparam int HOLDOFF = 2;
  localparam int TIMEOUT = 8;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  sync_event_sched_if #(.N(N), .IDW(IDW)) bus ();

  sync_event_sched #(.N(N), .IDW(IDW), .HOLDOFF(HOLDOFF), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: per-cell pending/level arrays plus one channel record with
  // its age in edges and the earliest edge at which a new grant is allowed.
  bit [N-1:0] m_pend, m_plev, m_last;
  int         m_lg;
  bit         m_act;
  int         m_id;
  bit         m_lvl;
  int         m_age;
  longint     m_free;
  longint     m_e = 0;
  int         m_cnt;
  bit         m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input bit [N-1:0] stb, input bit [N-1:0] lvl, input bit ack, input bit r);
    int g;
    m_e++;
    if (r) begin
      m_pend = '0; m_plev = '0; m_last = '0; m_lg = N - 1;
      m_act = 0; m_id = 0; m_lvl = 0; m_age = 0;
      m_cnt = 0; m_err = 0; m_free = m_e + 1;
      return;
    end
    g = -1;
    if (m_act) begin
      m_age++;
      if (ack || m_age == TIMEOUT) begin
        if (!ack) m_err = 1;
        m_act  = 0;
        m_free = m_e + 1 + HOLDOFF;
      end
    end else if (m_e >= m_free) begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (m_lg + k) % N;
        if (m_pend[i]) begin
          g = i;
          break;
        end
      end
      if (g >= 0) begin
        m_lg = g; m_act = 1; m_age = 0; m_id = g; m_lvl = m_plev[g];
        m_last[g] = m_plev[g];
        m_pend[g] = 0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (stb[i]) begin
        if (m_pend[i]) begin
          m_plev[i] = lvl[i];
          if (m_cnt < 255) m_cnt++;
        end else if (lvl[i] != m_last[i]) begin
          m_pend[i] = 1;
          m_plev[i] = lvl[i];
        end
      end
    end
  endtask

  task automatic step(input bit [N-1:0] stb, input bit [N-1:0] lvl, input bit ack, input bit r);
    bit exp_busy;
    bus.ev_strobe = stb;
    bus.ev_level  = lvl;
    bus.sync_ack  = ack;
    rst           = r;
    @(posedge clk);
    model(stb, lvl, ack, r);
    #1;
    exp_busy = m_act || (m_e + 1 < m_free) || (|m_pend);
    check("valid", bus.sync_valid, m_act);
    if (m_act) begin
      check("id", bus.sync_id, m_id);
      check("level", bus.sync_level, m_lvl);
    end
    check("pending", bus.pending, m_pend);
    check("busy", bus.busy, exp_busy);
    check("ccnt", bus.coalesce_cnt, m_cnt);
    check("err", bus.err_timeout, m_err);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!bus.sync_valid && n < 40) begin
      step('0, '0, 0, 0);
      n++;
    end
    check(tag, bus.sync_valid, 1);
  endtask

  task automatic drain();
    repeat (12) step('0, '0, 1, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int hi;
    bit starve;
    bus.ev_strobe = '0;
    bus.ev_level  = '0;
    bus.sync_ack  = 1'b0;
    rst           = 1'b1;

    step('0, '0, 0, 1);
    step('0, '0, 0, 1);
    check("rst_valid", bus.sync_valid, 0);
    check("rst_id", bus.sync_id, 0);
    check("rst_level", bus.sync_level, 0);
    check("rst_busy", bus.busy, 0);

    // single event
    step(4'b0100, 4'b0100, 0, 0);
    check("t1_pend", bus.pending, 4'b0100);
    check("t1_early", bus.sync_valid, 0);
    step('0, '0, 0, 0);
    check("t1_valid", bus.sync_valid, 1);
    check("t1_id", bus.sync_id, 2);
    check("t1_level", bus.sync_level, 1);
    step('0, '0, 1, 0);
    check("t1_drop", bus.sync_valid, 0);
    step('0, '0, 0, 0);
    check("t1_hold", bus.busy, 1);
    step('0, '0, 0, 0);
    check("t1_idle", bus.busy, 0);

    // redundant filter
    step('0, '0, 0, 1);
    step(4'b0010, 4'b0000, 0, 0);
    check("t2_nopend", bus.pending, 0);
    repeat (3) step('0, '0, 0, 0);
    check("t2_novalid", bus.sync_valid, 0);
    step(4'b0010, 4'b0010, 0, 0);
    step('0, '0, 0, 0);
    check("t2_id", bus.sync_id, 1);
    check("t2_level", bus.sync_level, 1);
    drain();

    // coalescing ending on level 1
    step('0, '0, 0, 1);
    step(4'b0001, 4'b0001, 0, 0);
    step(4'b1000, 4'b1000, 0, 0);
    step(4'b1000, 4'b0000, 0, 0);
    step(4'b1000, 4'b1000, 0, 0);
    check("t3_first", bus.sync_id, 0);
    step('0, '0, 1, 0);
    wait_valid("t3_wait");
    check("t3_id", bus.sync_id, 3);
    check("t3_level", bus.sync_level, 1);
    check("t3_ccnt", bus.coalesce_cnt, 2);
    drain();

    // coalescing ending on level 0 (equal to last) still issues once
    step('0, '0, 0, 1);
    step(4'b0001, 4'b0001, 0, 0);
    step(4'b1000, 4'b1000, 0, 0);
    step(4'b1000, 4'b1000, 0, 0);
    step(4'b1000, 4'b0000, 0, 0);
    step('0, '0, 1, 0);
    wait_valid("t3b_wait");
    check("t3b_id", bus.sync_id, 3);
    check("t3b_level", bus.sync_level, 0);
    check("t3b_ccnt", bus.coalesce_cnt, 2);
    drain();
    check("t3b_once", bus.busy, 0);

    // round robin
    step('0, '0, 0, 1);
    step(4'b1111, 4'b1111, 0, 0);
    for (int j = 0; j < N; j++) begin
      wait_valid("t4_wait");
      check("t4_order", bus.sync_id, j);
      step('0, '0, 1, 0);
    end
    step(4'b1001, 4'b0000, 0, 0);
    wait_valid("t4b_wait0");
    check("t4b_first", bus.sync_id, 0);
    step('0, '0, 1, 0);
    wait_valid("t4b_wait3");
    check("t4b_second", bus.sync_id, 3);
    drain();

    // ack timeout
    step('0, '0, 0, 1);
    step(4'b0110, 4'b0110, 0, 0);
    wait_valid("t5_wait");
    check("t5_id", bus.sync_id, 1);
    hi = 0;
    while (bus.sync_valid && hi < 20) begin
      hi++;
      step('0, '0, 0, 0);
    end
    check("t5_width", hi, TIMEOUT);
    check("t5_err", bus.err_timeout, 1);
    wait_valid("t5_next");
    check("t5_next_id", bus.sync_id, 2);
    step('0, '0, 1, 0);
    check("t5_sticky", bus.err_timeout, 1);
    drain();

    // reset in the middle of an issue
    step('0, '0, 0, 1);
    step(4'b0011, 4'b0011, 0, 0);
    wait_valid("t6_wait");
    check("t6_pend", bus.pending, 4'b0010);
    step('0, '0, 0, 1);
    check("t6_valid", bus.sync_valid, 0);
    check("t6_id", bus.sync_id, 0);
    check("t6_pending", bus.pending, 0);
    check("t6_busy", bus.busy, 0);
    step(4'b0001, 4'b0001, 0, 0);
    step('0, '0, 0, 0);
    check("t6_regrant", bus.sync_valid, 1);
    check("t6_regrant_id", bus.sync_id, 0);
    drain();

    // randomized traffic, with windows of ack starvation and rare resets
    starve = 0;
    for (int c = 0; c < 3000; c++) begin
      bit [N-1:0] s;
      bit [N-1:0] l;
      bit a;
      if (c % 40 == 0) starve = ($urandom_range(0, 3) == 0);
      s = N'($urandom & $urandom);
      l = N'($urandom);
      a = starve ? 1'b0 : ($urandom_range(0, 2) == 0);
      step(s, l, a, $urandom_range(0, 799) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
